timer_bank: RTL and testbench
=============================

TIMER_BANK -- requirements
Module: timer_bank

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent countdown channels (2..16).
REQ-002 Parameter MAX_MIN, default 10, maximum loadable minute value (1..99).
REQ-003 Derived CH_W = clog2(NUM_CH), channel index width; not user-overridden.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 tick  input  1  one-second strobe, one clk wide.
REQ-007 cmd_valid  input  1  command strobe; one command per cycle.
REQ-008 cmd_ch  input  CH_W  target channel.
REQ-009 cmd_op  input  2  00 SET, 01 START, 10 STOP, 11 CLEAR.
REQ-010 cmd_min / cmd_sec  input  8 each  load value for SET.
REQ-011 rd_ch  input  CH_W  status read select.
REQ-012 rd_min / rd_sec  output  8 each  count of channel rd_ch, combinational from registers.
REQ-013 running  output  NUM_CH  per-channel running flags.
REQ-014 done  output  NUM_CH  per-channel sticky expiry flags.
REQ-015 done_valid / done_ch  output  1 / CH_W  expiry event offer.
REQ-016 done_ready  input  1  event consumer accept.

Function
REQ-017 Each channel SHALL hold min, sec (8 b each), running, done, pending.
REQ-018 SET SHALL load min = min(cmd_min, MAX_MIN) and sec = min(cmd_sec, 59); if cmd_min > MAX_MIN, sec SHALL be 0; SET SHALL clear running, done, pending.
REQ-019 START SHALL set running and clear done if count is nonzero; START on 00:00 SHALL be ignored.
REQ-020 STOP SHALL clear running and retain count; CLEAR SHALL zero count, running, done, pending.
REQ-021 Commands with cmd_ch >= NUM_CH SHALL be ignored.
REQ-022 On tick, each running channel SHALL decrement: sec>0 -> sec-1; sec==0 and min>0 -> min-1, sec=59.
REQ-023 A tick taking a channel to 00:00 SHALL, on the same edge, clear running and set done and pending (flags visible the next cycle).
REQ-024 A command and tick to the same channel in one cycle: command SHALL win and that channel SHALL not decrement; other channels SHALL tick normally.
REQ-025 done_valid SHALL be high while any pending bit is set; done_ch SHALL be chosen round-robin starting at the channel after the last accepted one.
REQ-026 done_valid and done_ch SHALL remain stable until done_valid && done_ready; acceptance SHALL clear that pending bit and advance the pointer.
REQ-027 Re-expiry of a channel whose pending is still set SHALL merge (pending stays 1, no second event).
REQ-028 SET/CLEAR on a channel whose event is being offered SHALL withdraw it; done_valid/done_ch SHALL re-evaluate the next cycle.

Reset
REQ-029 reset_n low SHALL immediately zero all counts, running, done, pending, round-robin pointer; done_valid 0, done_ch 0.
REQ-030 Reset mid-count SHALL abandon all countdowns; no event SHALL be produced for them after release.

Configuration
REQ-031 Macro TIMER_BANK_AUTORELOAD_EN: when defined, port reload_en input NUM_CH SHALL exist; SET also stores the clipped value as a per-channel reload value; on expiry with reload_en[ch]=1 the channel SHALL reload it and keep running, still setting done and pending.
REQ-032 When TIMER_BANK_AUTORELOAD_EN is undefined, reload_en and reload storage SHALL be absent and every expiry SHALL stop the channel.

Verification
REQ-033 SET ch0 01:00, START, 60 ticks -> ch0 reads 00:00, running[0]=0, done[0]=1, done_valid=1, done_ch=0.
REQ-034 SET ch1 cmd_min=25, cmd_sec=40 (MAX_MIN=10) -> rd 10:00; SET ch2 03:75 -> rd 03:59.
REQ-035 ch0, ch2, ch3 at 00:01 running, one tick, done_ready=1 -> events ch0, ch2, ch3 on consecutive cycles, then done_valid=0.
REQ-036 ch1 running at 00:05, STOP coincident with tick -> remains 00:05, running[1]=0; START plus 5 ticks -> done[1]=1.
REQ-037 ch0 running 02:00, reset_n low 1 cycle mid-count -> all outputs zero, no event after release.
REQ-038 With TIMER_BANK_AUTORELOAD_EN, ch0 SET 00:03, reload_en[0]=1, START, 6 ticks -> two events for ch0, rd 00:03, running[0]=1.

Source files
------------

// File: rtl/timer_bank.sv
// Bank of NUM_CH independent mm:ss countdown timers with a round-robin expiry event port.
// Define TIMER_BANK_AUTORELOAD_EN to add reload_en and per-channel reload values.
module timer_bank #(
    parameter int  NUM_CH  = 4,
    parameter int  MAX_MIN = 10,
    localparam int CH_W    = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              tick,
    input  logic              cmd_valid,
    input  logic [CH_W-1:0]   cmd_ch,
    input  logic [1:0]        cmd_op,
    input  logic [7:0]        cmd_min,
    input  logic [7:0]        cmd_sec,
`ifdef TIMER_BANK_AUTORELOAD_EN
    input  logic [NUM_CH-1:0] reload_en,
`endif
    input  logic [CH_W-1:0]   rd_ch,
    output logic [7:0]        rd_min,
    output logic [7:0]        rd_sec,
    output logic [NUM_CH-1:0] running,
    output logic [NUM_CH-1:0] done,
    output logic              done_valid,
    output logic [CH_W-1:0]   done_ch,
    input  logic              done_ready
);

    localparam logic [7:0] MAX_MIN_V = 8'(MAX_MIN);
    localparam logic [7:0] MAX_SEC_V = 8'd59;
    localparam logic [1:0] OP_SET    = 2'b00;
    localparam logic [1:0] OP_START  = 2'b01;
    localparam logic [1:0] OP_STOP   = 2'b10;

    logic [7:0]        min_q [NUM_CH];
    logic [7:0]        min_d [NUM_CH];
    logic [7:0]        sec_q [NUM_CH];
    logic [7:0]        sec_d [NUM_CH];
`ifdef TIMER_BANK_AUTORELOAD_EN
    logic [7:0]        rl_min_q [NUM_CH];
    logic [7:0]        rl_min_d [NUM_CH];
    logic [7:0]        rl_sec_q [NUM_CH];
    logic [7:0]        rl_sec_d [NUM_CH];
`endif
    logic [NUM_CH-1:0] run_q, run_d;
    logic [NUM_CH-1:0] done_q, done_d;
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [CH_W-1:0]   ptr_q, ptr_d;
    logic [CH_W-1:0]   lock_ch_q, lock_ch_d;
    logic              lock_q, lock_d;
    logic [7:0]        set_min, set_sec;
    logic [CH_W-1:0]   pick_ch, cand;
    logic              accept, withdraw;
    int                idx;

    // An out-of-range minute value saturates the whole load, not only the minutes.
    always_comb begin
        set_min = cmd_min;
        set_sec = (cmd_sec > MAX_SEC_V) ? MAX_SEC_V : cmd_sec;
        if (cmd_min > MAX_MIN_V) begin
            set_min = MAX_MIN_V;
            set_sec = '0;
        end
    end

    // Scan downward so the lowest offset from ptr_q is the last (winning) assignment.
    always_comb begin
        pick_ch = '0;
        idx     = 0;
        cand    = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            cand = CH_W'(idx);
            if (pend_q[cand]) pick_ch = cand;
        end
    end

    // Offer handshake: done_valid/done_ch hold until done_valid && done_ready.
    // Once an offer goes unaccepted the channel is latched so later expiries cannot reorder it.
    assign done_valid = |pend_q;
    assign done_ch    = lock_q ? lock_ch_q : pick_ch;
    assign accept     = done_valid && done_ready;
    assign withdraw   = cmd_valid && (cmd_ch == done_ch) &&
                        (cmd_op == OP_SET || cmd_op == 2'b11);

    always_comb begin
        lock_d    = done_valid && !done_ready && !withdraw;
        lock_ch_d = done_ch;
        ptr_d     = ptr_q;
        if (accept) ptr_d = (done_ch == CH_W'(NUM_CH - 1)) ? '0 : done_ch + 1'b1;
    end

    always_comb begin
        min_d  = min_q;
        sec_d  = sec_q;
        run_d  = run_q;
        done_d = done_q;
        pend_d = pend_q;
`ifdef TIMER_BANK_AUTORELOAD_EN
        rl_min_d = rl_min_q;
        rl_sec_d = rl_sec_q;
`endif
        if (accept) pend_d[done_ch] = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cmd_valid && cmd_ch == CH_W'(i)) begin
                case (cmd_op)
                    OP_SET: begin
                        min_d[i]  = set_min;
                        sec_d[i]  = set_sec;
                        run_d[i]  = 1'b0;
                        done_d[i] = 1'b0;
                        pend_d[i] = 1'b0;
`ifdef TIMER_BANK_AUTORELOAD_EN
                        rl_min_d[i] = set_min;
                        rl_sec_d[i] = set_sec;
`endif
                    end
                    OP_START: begin
                        if (min_q[i] != '0 || sec_q[i] != '0) begin
                            run_d[i]  = 1'b1;
                            done_d[i] = 1'b0;
                        end
                    end
                    OP_STOP: run_d[i] = 1'b0;
                    default: begin
                        min_d[i]  = '0;
                        sec_d[i]  = '0;
                        run_d[i]  = 1'b0;
                        done_d[i] = 1'b0;
                        pend_d[i] = 1'b0;
                    end
                endcase
            end else if (tick && run_q[i]) begin
                if (sec_q[i] != '0) begin
                    sec_d[i] = sec_q[i] - 8'd1;
                end else begin
                    min_d[i] = min_q[i] - 8'd1;
                    sec_d[i] = MAX_SEC_V;
                end
                if (min_q[i] == '0 && sec_q[i] == 8'd1) begin
                    done_d[i] = 1'b1;
                    pend_d[i] = 1'b1;
`ifdef TIMER_BANK_AUTORELOAD_EN
                    if (reload_en[i]) begin
                        min_d[i] = rl_min_q[i];
                        sec_d[i] = rl_sec_q[i];
                    end else begin
                        run_d[i] = 1'b0;
                    end
`else
                    run_d[i] = 1'b0;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                min_q[i] <= '0;
                sec_q[i] <= '0;
`ifdef TIMER_BANK_AUTORELOAD_EN
                rl_min_q[i] <= '0;
                rl_sec_q[i] <= '0;
`endif
            end
            run_q     <= '0;
            done_q    <= '0;
            pend_q    <= '0;
            ptr_q     <= '0;
            lock_q    <= 1'b0;
            lock_ch_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                min_q[i] <= min_d[i];
                sec_q[i] <= sec_d[i];
`ifdef TIMER_BANK_AUTORELOAD_EN
                rl_min_q[i] <= rl_min_d[i];
                rl_sec_q[i] <= rl_sec_d[i];
`endif
            end
            run_q     <= run_d;
            done_q    <= done_d;
            pend_q    <= pend_d;
            ptr_q     <= ptr_d;
            lock_q    <= lock_d;
            lock_ch_q <= lock_ch_d;
        end
    end

    assign rd_min  = (int'(rd_ch) < NUM_CH) ? min_q[rd_ch] : '0;
    assign rd_sec  = (int'(rd_ch) < NUM_CH) ? sec_q[rd_ch] : '0;
    assign running = run_q;
    assign done    = done_q;

endmodule

// File: tb/tb_timer_bank.sv
// Self-checking bench for timer_bank: directed command/tick sequences, expiry events scoreboarded.
module tb_timer_bank;

    localparam int NUM_CH  = 4;
    localparam int MAX_MIN = 10;
    localparam int CH_W    = $clog2(NUM_CH);

    localparam logic [1:0] OP_SET   = 2'b00;
    localparam logic [1:0] OP_START = 2'b01;
    localparam logic [1:0] OP_STOP  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              tick;
    logic              cmd_valid;
    logic [CH_W-1:0]   cmd_ch;
    logic [1:0]        cmd_op;
    logic [7:0]        cmd_min;
    logic [7:0]        cmd_sec;
    logic [CH_W-1:0]   rd_ch;
    logic [7:0]        rd_min;
    logic [7:0]        rd_sec;
    logic [NUM_CH-1:0] running;
    logic [NUM_CH-1:0] done;
    logic              done_valid;
    logic [CH_W-1:0]   done_ch;
    logic              done_ready;
`ifdef TIMER_BANK_AUTORELOAD_EN
    logic [NUM_CH-1:0] reload_en;
`endif

    int checks   = 0;
    int failures = 0;
    logic [CH_W-1:0] exp_q[$];

    always #5 clk = ~clk;

    timer_bank #(.NUM_CH(NUM_CH), .MAX_MIN(MAX_MIN)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tick       (tick),
        .cmd_valid  (cmd_valid),
        .cmd_ch     (cmd_ch),
        .cmd_op     (cmd_op),
        .cmd_min    (cmd_min),
        .cmd_sec    (cmd_sec),
`ifdef TIMER_BANK_AUTORELOAD_EN
        .reload_en  (reload_en),
`endif
        .rd_ch      (rd_ch),
        .rd_min     (rd_min),
        .rd_sec     (rd_sec),
        .running    (running),
        .done       (done),
        .done_valid (done_valid),
        .done_ch    (done_ch),
        .done_ready (done_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_cmd(input int ch, input logic [1:0] op, input int mn, input int sc,
                          input logic with_tick);
        cmd_valid = 1'b1;
        cmd_ch    = CH_W'(ch);
        cmd_op    = op;
        cmd_min   = 8'(mn);
        cmd_sec   = 8'(sc);
        tick      = with_tick;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        tick      = 1'b0;
    endtask

    task automatic do_tick(input int n);
        repeat (n) begin
            tick = 1'b1;
            @(posedge clk); #1;
            tick = 1'b0;
        end
    endtask

    task automatic rd_check(input string tag, input int ch, input int mn, input int sc);
        rd_ch = CH_W'(ch);
        #1;
        check({tag, "_min"}, 32'(rd_min), 32'(mn));
        check({tag, "_sec"}, 32'(rd_sec), 32'(sc));
    endtask

    // Every accepted expiry event must match the next expected channel.
    always @(negedge clk) begin
        if (reset_n && done_valid && done_ready) begin
            if (exp_q.size() == 0) check("evt_unexpected", 32'(done_ch) + 32'h100, 32'h0);
            else check("evt_ch", 32'(done_ch), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; tick = 1'b0; cmd_valid = 1'b0; cmd_ch = '0; cmd_op = '0;
        cmd_min = '0; cmd_sec = '0; rd_ch = '0; done_ready = 1'b0;
`ifdef TIMER_BANK_AUTORELOAD_EN
        reload_en = '0;
`endif
        repeat (2) @(posedge clk); #1;
        check("rst_running", 32'(running), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_valid", 32'(done_valid), 32'h0);
        check("rst_done_ch", 32'(done_ch), 32'h0);
        rd_check("rst_rd", 0, 0, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // One minute on ch0 expires after exactly 60 ticks.
        do_cmd(0, OP_SET, 1, 0, 1'b0);
        rd_check("set0", 0, 1, 0);
        do_cmd(0, OP_START, 0, 0, 1'b0);
        check("start0_run", 32'(running[0]), 32'h1);
        do_tick(1);
        rd_check("t1", 0, 0, 59);
        do_tick(58);
        rd_check("t59", 0, 0, 1);
        check("t59_run", 32'(running[0]), 32'h1);
        check("t59_valid", 32'(done_valid), 32'h0);
        exp_q.push_back(CH_W'(0));
        do_tick(1);
        rd_check("t60", 0, 0, 0);
        check("t60_run", 32'(running[0]), 32'h0);
        check("t60_done", 32'(done[0]), 32'h1);
        check("t60_valid", 32'(done_valid), 32'h1);
        check("t60_done_ch", 32'(done_ch), 32'h0);
        done_ready = 1'b1;
        @(posedge clk); #1;
        done_ready = 1'b0;
        check("acc0_valid", 32'(done_valid), 32'h0);
        check("acc0_done_sticky", 32'(done[0]), 32'h1);

        // Load clipping and ignored START on zero count.
        do_cmd(1, OP_SET, 25, 40, 1'b0);
        rd_check("clip_25_40", 1, 10, 0);
        do_cmd(2, OP_SET, 3, 75, 1'b0);
        rd_check("clip_3_75", 2, 3, 59);
        do_cmd(3, OP_SET, 10, 59, 1'b0);
        rd_check("clip_10_59", 3, 10, 59);
        do_cmd(3, OP_SET, 11, 30, 1'b0);
        rd_check("clip_11_30", 3, 10, 0);
        do_cmd(3, OP_CLEAR, 0, 0, 1'b0);
        do_cmd(3, OP_START, 0, 0, 1'b0);
        check("start_zero_ign", 32'(running[3]), 32'h0);
        rd_check("clear3", 3, 0, 0);
        do_cmd(1, OP_START, 0, 0, 1'b0);
        check("start_10_00", 32'(running[1]), 32'h1);
        do_cmd(1, OP_STOP, 0, 0, 1'b0);
        check("stop1_run", 32'(running[1]), 32'h0);
        rd_check("stop1_keep", 1, 10, 0);

        // STOP coincident with tick wins on ch1; ch2 still ticks.
        do_cmd(1, OP_SET, 0, 5, 1'b0);
        do_cmd(1, OP_START, 0, 0, 1'b0);
        do_cmd(2, OP_SET, 0, 10, 1'b0);
        do_cmd(2, OP_START, 0, 0, 1'b0);
        do_cmd(1, OP_STOP, 0, 0, 1'b1);
        rd_check("stop_tick_ch1", 1, 0, 5);
        check("stop_tick_run1", 32'(running[1]), 32'h0);
        rd_check("stop_tick_ch2", 2, 0, 9);
        do_cmd(1, OP_START, 0, 0, 1'b0);
        do_tick(4);
        check("ch1_t4_done", 32'(done[1]), 32'h0);
        do_tick(1);
        check("ch1_t5_done", 32'(done[1]), 32'h1);
        check("ch1_t5_run", 32'(running[1]), 32'h0);
        check("ch1_t5_valid", 32'(done_valid), 32'h1);
        check("ch1_t5_done_ch", 32'(done_ch), 32'h1);
        rd_check("ch2_after", 2, 0, 4);
        // CLEAR withdraws the pending offer without an acceptance.
        do_cmd(1, OP_CLEAR, 0, 0, 1'b0);
        check("withdraw_valid", 32'(done_valid), 32'h0);
        check("withdraw_done", 32'(done[1]), 32'h0);
        do_cmd(2, OP_CLEAR, 0, 0, 1'b0);

        // Offer stays on ch3 even after ch1 (nearer the pointer) expires.
        do_cmd(3, OP_SET, 0, 1, 1'b0);
        do_cmd(1, OP_SET, 0, 2, 1'b0);
        do_cmd(3, OP_START, 0, 0, 1'b0);
        do_cmd(1, OP_START, 0, 0, 1'b0);
        do_tick(1);
        check("hold_first", 32'(done_ch), 32'h3);
        do_tick(1);
        check("hold_second_valid", 32'(done_valid), 32'h1);
        check("hold_second_ch", 32'(done_ch), 32'h3);
        exp_q.push_back(CH_W'(3));
        exp_q.push_back(CH_W'(1));
        done_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        done_ready = 1'b0;
        check("hold_drain_valid", 32'(done_valid), 32'h0);

        // Reset mid-count abandons everything.
        do_cmd(0, OP_SET, 2, 0, 1'b0);
        do_cmd(0, OP_START, 0, 0, 1'b0);
        do_cmd(2, OP_SET, 0, 1, 1'b0);
        do_cmd(2, OP_START, 0, 0, 1'b0);
        do_tick(3);
        check("pre_rst_valid", 32'(done_valid), 32'h1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_running", 32'(running), 32'h0);
        check("mid_rst_done", 32'(done), 32'h0);
        check("mid_rst_valid", 32'(done_valid), 32'h0);
        check("mid_rst_done_ch", 32'(done_ch), 32'h0);
        rd_check("mid_rst_rd", 0, 0, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        done_ready = 1'b1;
        do_tick(125);
        done_ready = 1'b0;
        check("post_rst_valid", 32'(done_valid), 32'h0);
        check("post_rst_running", 32'(running), 32'h0);
        rd_check("post_rst_rd", 0, 0, 0);

        // Round robin from a fresh pointer: ch0, ch2, ch3 on consecutive cycles.
        do_cmd(0, OP_SET, 0, 1, 1'b0);
        do_cmd(2, OP_SET, 0, 1, 1'b0);
        do_cmd(3, OP_SET, 0, 1, 1'b0);
        do_cmd(0, OP_START, 0, 0, 1'b0);
        do_cmd(2, OP_START, 0, 0, 1'b0);
        do_cmd(3, OP_START, 0, 0, 1'b0);
        exp_q.push_back(CH_W'(0));
        exp_q.push_back(CH_W'(2));
        exp_q.push_back(CH_W'(3));
        done_ready = 1'b1;
        do_tick(1);
        check("rr_done_flags", 32'(done), 32'hd);
        check("rr_c0", 32'(done_ch), 32'h0);
        @(posedge clk); #1;
        check("rr_c1", 32'(done_ch), 32'h2);
        @(posedge clk); #1;
        check("rr_c2", 32'(done_ch), 32'h3);
        @(posedge clk); #1;
        check("rr_drained", 32'(done_valid), 32'h0);
        done_ready = 1'b0;

`ifdef TIMER_BANK_AUTORELOAD_EN
        // Autoreload: two expiries of ch0 in six ticks, channel keeps running.
        do_cmd(0, OP_SET, 0, 3, 1'b0);
        reload_en = 4'b0001;
        do_cmd(0, OP_START, 0, 0, 1'b0);
        exp_q.push_back(CH_W'(0));
        exp_q.push_back(CH_W'(0));
        done_ready = 1'b1;
        do_tick(6);
        rd_check("reload_rd", 0, 0, 3);
        check("reload_run", 32'(running[0]), 32'h1);
        check("reload_done", 32'(done[0]), 32'h1);
        @(posedge clk); #1;
        done_ready = 1'b0;
        reload_en = '0;
        do_cmd(0, OP_CLEAR, 0, 0, 1'b0);
`endif

        repeat (2) @(posedge clk);
        #1;
        check("sb_empty", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
